// File: rtl/mem_wb_commit.sv
// MEM/WB pipeline register with regfile write port, architectural HI/LO
// ownership (with WB-stage bypass to EX) and a retired-instruction counter.
module mem_wb_commit #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [5:0]    stall,
    input  logic          flush,
    input  logic          mem_valid,
    input  logic          mem_wreg,
    input  logic [AW-1:0] mem_wd,
    input  logic [DW-1:0] mem_wdata,
    input  logic          mem_whilo,
    input  logic [DW-1:0] mem_hi,
    input  logic [DW-1:0] mem_lo,
    output logic          wb_wreg,
    output logic [AW-1:0] wb_wd,
    output logic [DW-1:0] wb_wdata,
    output logic          wb_whilo,
    output logic [DW-1:0] wb_hi,
    output logic [DW-1:0] wb_lo,
    output logic [DW-1:0] hi_rd,
    output logic [DW-1:0] lo_rd,
    output logic [CW-1:0] retired
);

    logic          wb_valid;
    logic [DW-1:0] hi_q;
    logic [DW-1:0] lo_q;
    logic          load_bubble;
    logic          load_mem;
    logic          wb_commit;
    logic          unused_stall;

    assign unused_stall = ^stall[3:0];

    always_comb begin
        load_bubble = flush || (stall[4] && !stall[5]);
        load_mem    = !stall[4];
        wb_commit   = !stall[5];
    end

    // Reset and bubble share the all-zero path; flush outranks the MEM load.
    always_ff @(posedge clk) begin
        if (rst || load_bubble) begin
            wb_valid <= 1'b0;
            wb_wreg  <= 1'b0;
            wb_wd    <= '0;
            wb_wdata <= '0;
            wb_whilo <= 1'b0;
            wb_hi    <= '0;
            wb_lo    <= '0;
        end else if (load_mem) begin
            wb_valid <= mem_valid;
            wb_wreg  <= mem_wreg;
            wb_wd    <= mem_wd;
            wb_wdata <= mem_wdata;
            wb_whilo <= mem_whilo;
            wb_hi    <= mem_hi;
            wb_lo    <= mem_lo;
        end
    end

    // A WB-stalled entry is held in the register above and commits on release.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q    <= '0;
            lo_q    <= '0;
            retired <= '0;
        end else if (wb_commit) begin
            if (wb_whilo) begin
                hi_q <= wb_hi;
                lo_q <= wb_lo;
            end
            if (wb_valid) begin
                retired <= retired + CW'(1);
            end
        end
    end

    always_comb begin
        hi_rd = wb_whilo ? wb_hi : hi_q;
        lo_rd = wb_whilo ? wb_lo : lo_q;
    end

endmodule
